// File: rtl/find_pointer_pkg.sv
// Shared constants and types for the sorter index-matching block.
package find_pointer_pkg;

  localparam int unsigned N  = 9;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;

  typedef logic [W-1:0]  data_t;
  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t NO_MATCH = 4'hF;

endpackage

// File: rtl/occurrence_select.sv
// Returns the index of the (rank+1)-th set bit of an equality mask, or NO_MATCH.
module occurrence_select
  import find_pointer_pkg::*;
(
  input  logic [N-1:0] mask_i,
  input  ptr_t         rank_i,
  output ptr_t         ptr_o
);

  ptr_t seen;
  logic found;

  always_comb begin
    seen  = '0;
    found = 1'b0;
    ptr_o = NO_MATCH;
    for (int j = 0; j < N; j++) begin
      if (mask_i[j] && !found) begin
        if (seen == rank_i) begin
          ptr_o = PW'(j);
          found = 1'b1;
        end else begin
          seen = seen + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/find_pointer.sv
// For each sorted element, registers the position in arr holding the same value;
// duplicates are matched in order of occurrence.
module find_pointer
  import find_pointer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sort1,
  input  logic [7:0] sort2,
  input  logic [7:0] sort3,
  input  logic [7:0] sort4,
  input  logic [7:0] sort5,
  input  logic [7:0] sort6,
  input  logic [7:0] sort7,
  input  logic [7:0] sort8,
  input  logic [7:0] sort9,
  input  logic [7:0] arr1,
  input  logic [7:0] arr2,
  input  logic [7:0] arr3,
  input  logic [7:0] arr4,
  input  logic [7:0] arr5,
  input  logic [7:0] arr6,
  input  logic [7:0] arr7,
  input  logic [7:0] arr8,
  input  logic [7:0] arr9,
  output logic [3:0] pointer1,
  output logic [3:0] pointer2,
  output logic [3:0] pointer3,
  output logic [3:0] pointer4,
  output logic [3:0] pointer5,
  output logic [3:0] pointer6,
  output logic [3:0] pointer7,
  output logic [3:0] pointer8,
  output logic [3:0] pointer9,
  output logic       all_found
);

  data_t        sort_a [N];
  data_t        arr_a  [N];
  ptr_t         rank   [N];
  logic [N-1:0] mask   [N];
  ptr_t         ptr_d  [N];
  ptr_t         ptr_q  [N];
  logic         all_found_d, all_found_q;

  assign sort_a = '{sort1, sort2, sort3, sort4, sort5, sort6, sort7, sort8, sort9};
  assign arr_a  = '{arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9};

  // Rank of sort[i]: how many earlier sort entries carry the same value.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rank[i] = '0;
      for (int j = 0; j < i; j++) begin
        if (sort_a[j] == sort_a[i]) begin
          rank[i] = rank[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mask[i][j] = (arr_a[j] == sort_a[i]);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_sel
    occurrence_select u_sel (
      .mask_i (mask[i]),
      .rank_i (rank[i]),
      .ptr_o  (ptr_d[i])
    );
  end

  always_comb begin
    all_found_d = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (ptr_d[i] == NO_MATCH) begin
        all_found_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ptr_q[i] <= NO_MATCH;
      end
      all_found_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ptr_q[i] <= ptr_d[i];
      end
      all_found_q <= all_found_d;
    end
  end

  assign pointer1  = ptr_q[0];
  assign pointer2  = ptr_q[1];
  assign pointer3  = ptr_q[2];
  assign pointer4  = ptr_q[3];
  assign pointer5  = ptr_q[4];
  assign pointer6  = ptr_q[5];
  assign pointer7  = ptr_q[6];
  assign pointer8  = ptr_q[7];
  assign pointer9  = ptr_q[8];
  assign all_found = all_found_q;

endmodule

// File: tb/tb_find_pointer.sv
// Directed bench for find_pointer with hand-computed expected pointers.
module tb_find_pointer;

  logic       clk;
  logic       rst_n;
  logic [7:0] s [9];
  logic [7:0] a [9];
  logic [3:0] p [9];
  logic       all_found;

  int compared;
  int mismatched;

  find_pointer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sort1     (s[0]),
    .sort2     (s[1]),
    .sort3     (s[2]),
    .sort4     (s[3]),
    .sort5     (s[4]),
    .sort6     (s[5]),
    .sort7     (s[6]),
    .sort8     (s[7]),
    .sort9     (s[8]),
    .arr1      (a[0]),
    .arr2      (a[1]),
    .arr3      (a[2]),
    .arr4      (a[3]),
    .arr5      (a[4]),
    .arr6      (a[5]),
    .arr7      (a[6]),
    .arr8      (a[7]),
    .arr9      (a[8]),
    .pointer1  (p[0]),
    .pointer2  (p[1]),
    .pointer3  (p[2]),
    .pointer4  (p[3]),
    .pointer5  (p[4]),
    .pointer6  (p[5]),
    .pointer7  (p[6]),
    .pointer8  (p[7]),
    .pointer9  (p[8]),
    .all_found (all_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vectors are written element 1 first (leftmost).
  task automatic load(input logic [71:0] sv, input logic [71:0] av);
    for (int i = 0; i < 9; i++) begin
      s[i] = sv[71-8*i -: 8];
      a[i] = av[71-8*i -: 8];
    end
  endtask

  task automatic check(input string tag, input logic [35:0] exp, input logic expf);
    logic [3:0] e;
    for (int i = 0; i < 9; i++) begin
      e = exp[35-4*i -: 4];
      compared++;
      assert (p[i] === e) else begin
        mismatched++;
        $error("FAIL %s pointer%0d: observed %h expected %h", tag, i + 1, p[i], e);
      end
    end
    compared++;
    assert (all_found === expf) else begin
      mismatched++;
      $error("FAIL %s all_found: observed %b expected %b", tag, all_found, expf);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    load({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90},
         {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90});
    // Reset wins even with valid data present.
    tick();
    check("reset", {9{4'hF}}, 1'b0);

    rst_n = 1'b1;
    tick();
    check("identity", {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}, 1'b1);

    load({8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1},
         {8'd1, 8'd3, 8'd4, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1, 8'd1});
    tick();
    check("dups", {4'd1, 4'd0, 4'd2, 4'd5, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8}, 1'b1);

    a[8] = 8'd7;
    tick();
    check("missing", {4'd1, 4'd0, 4'd2, 4'd5, 4'd3, 4'd4, 4'd6, 4'd7, 4'hF}, 1'b0);

    load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
         {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    tick();
    check("reverse", {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1);

    // New inputs must not show before the next edge.
    load({9{8'hFF}}, {9{8'hFF}});
    #1;
    check("latency", {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1);
    tick();
    check("allequal", {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}, 1'b1);

    load({8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
         {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    tick();
    check("absent", {4'hF, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7}, 1'b0);

    load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
         {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    rst_n = 1'b0;
    tick();
    check("midreset", {9{4'hF}}, 1'b0);

    rst_n = 1'b1;
    load({8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1},
         {8'd1, 8'd3, 8'd4, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1, 8'd1});
    tick();
    check("resume", {4'd1, 4'd0, 4'd2, 4'd5, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8}, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/find_pointer.md
# find_pointer

Registered index-matching block for the 9-element sorter datapath. For each element of a reordered vector `sort1..sort9`, it reports the 0-based position in the original vector `arr1..arr9` holding the same value. Equal values are matched in order of occurrence, so a true permutation yields a permutation of 0..8. The pointers feed the downstream reorder/gather stage.

## Interface
- `N`, 9: number of elements (fixed port count, documented constant)
- `W`, 8: data width
- `PW`, 4: pointer width
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  synchronous, active-low reset
- `sort1..sort9`  input  8 each  reordered values
- `arr1..arr9`  input  8 each  original values
- `pointer1..pointer9`  output  4 each  0-based index into `arr`; `4'hF` = no match
- `all_found`  output  1  high when no pointer equals `4'hF`

## Operation
- Index 0 corresponds to `arr1` and index 8 to `arr9`. Same mapping for `sort`.
- Occurrence rank of `sort_i`: r_i = count of j < i with `sort_j == sort_i`.
- `pointer_i` = index of the (r_i+1)-th element of `arr`, scanning 0 to 8, whose value equals `sort_i`.
- If `arr` holds r_i or fewer copies of that value, `pointer_i = 4'hF`.
- Comparison is unsigned equality on all 8 bits.
- When the multisets of `sort` and `arr` are equal, pointers form a permutation of 0..8 and `all_found = 1`.
- Values 9..14 are never produced.

## Timing
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge k appear on outputs after edge k.
- No handshake. The block recomputes every cycle, giving throughput of 1 vector/cycle.
- Reset is sampled only on a rising `clk` with `rst_n = 0`:
  - all `pointer_i` → `4'hF`
  - `all_found` → 0
- Reset has priority over new data.
- First valid result appears one edge after `rst_n` rises, with inputs stable at that edge.
- Inputs changing every cycle are handled independently; there is no state other than the output registers.
- Combinational path: rank compute, 9×9 equality matrix, priority select. It must close at the target clock in one cycle.

## Structure
- Shared package `find_pointer_pkg`:
  - `N = 9`, `W = 8`, `PW = 4`
  - `NO_MATCH = 4'hF`
  - typedefs `data_t` (8-bit) and `ptr_t` (4-bit)
- Sub-module `occurrence_select`, instantiated 9 times:
  - inputs: 9-bit equality mask (`arr_j == sort_i`) and a rank (0..8)
  - output: index of the (rank+1)-th set bit, or `NO_MATCH`
- Top-level responsibilities:
  - flatten ports into arrays
  - compute ranks with a triangular compare
  - build masks and register outputs

## Test plan
- Identity: `sort = arr = 10,20,...,90` → pointers 0..8, `all_found = 1`.
- Duplicates:
  - stimulus: `sort = 3,1,4,1,5,9,1,1,1`, `arr = 1,3,4,5,9,1,1,1,1`
  - response: pointers `1,0,2,5,3,4,6,7,8`, `all_found = 1`, one cycle after the edge
- Missing value: `arr9` changed from 1 to 7 in the duplicates case → `pointer9 = 4'hF`, `all_found = 0`.
- Reverse permutation: `arr = 1..9`, `sort = 9..1` → pointers `8,7,...,0`.
- All equal: all `sort` and all `arr` = 0xFF → pointers 0..8 in order.
- Reset mid-stream: `rst_n` low for one edge during changing stimulus → all pointers `4'hF` and `all_found = 0` that cycle; correct results resume one edge after release.
